mem_burst_master: RTL and testbench
===================================

// Module: mem_burst_master
// PURPOSE
// - Initiator for the 256x8 data memory port (Address, Data_in, W_En, R_En, Data_out).
// - Takes one burst command (read or write, base address, length) per handshake.
// - Streams write bytes in, or read bytes out, through valid/ready channels.
// - Sits between the MEM stage or loader logic and the data memory, sequencing consecutive accesses.
// PARAMETERS
// - ADDR_W  8  memory address width; addresses wrap modulo 2^ADDR_W
// - DATA_W  8  memory data width
// - LEN_W   4  burst length field; beats = Req_Len+1 (1..16)
// PORTS
// - CLK          in   1       clock; all state updates on posedge
// - RST          in   1       reset: synchronous, active-high
// - Req_Valid    in   1       command valid
// - Req_Ready    out  1       command accepted when Req_Valid&&Req_Ready; high only in IDLE
// - Req_Write    in   1       1=write burst, 0=read burst
// - Req_Addr     in   ADDR_W  base address
// - Req_Len      in   LEN_W   beats minus one
// - Wr_Data      in   DATA_W  write stream byte
// - Wr_Valid     in   1       write byte valid
// - Wr_Ready     out  1       high in WRITE state only
// - Rd_Data      out  DATA_W  read stream byte (registered)
// - Rd_Valid     out  1       read byte valid
// - Rd_Ready     in   1       consumer accepts read byte
// - Busy         out  1       state != IDLE
// - Done         out  1       one-cycle pulse after last beat of a burst completes
// - Mem_Address  out  ADDR_W  to memory Address
// - Mem_Wdata    out  DATA_W  to memory Data_in
// - Mem_W_En     out  1       to memory W_En
// - Mem_R_En     out  1       to memory R_En
// - Mem_Rdata    in   DATA_W  from memory Data_out (combinational read)
// BEHAVIOUR
// - Reset: state=IDLE; addr/count regs=0; Rd_Valid=0; Rd_Data=0; Done=0.
//   Mem_W_En=0, Mem_R_En=0, Mem_Address=0, Mem_Wdata=0.
//   Reset mid-burst aborts at once: no further memory strobes; a pending Rd_Valid is dropped.
// - FSM: IDLE, WRITE, READ, DRAIN.
//   - IDLE: on accept, latch addr=Req_Addr, cnt=Req_Len; next state WRITE if Req_Write, else READ.
//   - WRITE: Wr_Ready=1. When Wr_Valid=1: Mem_W_En=1, Mem_Address=addr, Mem_Wdata=Wr_Data
//     (all combinational; memory captures at the same posedge). Then addr+=1 (wrap 255->0).
//     If cnt==0, go to IDLE and pulse Done the next cycle; else cnt-=1. Wr_Valid=0 stalls with no strobe.
//   - READ: issue when the output slot is free (!Rd_Valid || Rd_Ready).
//     Issue drives Mem_R_En=1, Mem_Address=addr; Rd_Data<=Mem_Rdata, Rd_Valid<=1, addr+=1.
//     If cnt==0, go to DRAIN; else cnt-=1. Slot full with no Rd_Ready: Mem_R_En=0, hold.
//   - DRAIN: no memory strobes. When Rd_Valid&&Rd_Ready: Rd_Valid<=0, go to IDLE, pulse Done.
// - Read throughput: 1 byte/cycle while Rd_Ready=1. Latency from issue cycle to Rd_Valid is 1 cycle.
// - Write throughput: 1 byte/cycle while Wr_Valid=1. Write latency is 0 (same-cycle strobe).
// - Mem_Address=0 and Mem_Wdata=0 whenever no strobe is active. Mem_W_En and Mem_R_En are never high together.
// - Done is registered. Req_Ready=0 during the Done cycle is not required: IDLE is already entered.
// - Rd_Valid/Rd_Data are stable while Rd_Valid&&!Rd_Ready. Req fields are ignored outside IDLE.
// STRUCTURE
// - Shared package mem_pkg: ADDR_W/DATA_W defaults, state encoding localparams
//   (ST_IDLE=2'd0, ST_WRITE=2'd1, ST_READ=2'd2, ST_DRAIN=2'd3).
// - Single module with no sub-modules. Read output register is inline (1-entry slot).
// TESTING
// - Single write Addr=8'h10 Len=0 Wr_Data=8'hA5 -> one Mem_W_En cycle at 8'h10; Done 1 cycle later; mem[16]=A5.
// - Write burst Addr=8'hFE Len=3 data 1,2,3,4 -> writes at FE,FF,00,01 (wrap); readback burst returns 1,2,3,4 in order.
// - Read burst Len=3 with Rd_Ready toggling 1,0,0,1,... -> no byte lost or duplicated;
//   Mem_R_En=0 in stall cycles; Done after the 4th accept.
// - Write burst with Wr_Valid gaps -> Mem_W_En only in Wr_Valid cycles; exactly Len+1 writes.
// - RST asserted in cycle 2 of a Len=7 write -> no W_En after reset; Busy=0, Rd_Valid=0; a new command is accepted next.
// - Req_Valid held during a burst with different fields -> ignored; Req_Ready=0 until IDLE.

Source files
------------

// File: rtl/mem_burst_master_pkg.sv
// mem_pkg: shared widths and FSM state encoding for the burst master
package mem_pkg;
    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;
    localparam int MEM_LEN_W  = 4;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;
endpackage

// File: rtl/mem_burst_master_if.sv
// mem_burst_master_if: command, stream and memory-port signals of the burst master
interface mem_burst_master_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int LEN_W  = MEM_LEN_W
);
    logic              Req_Valid;
    logic              Req_Ready;
    logic              Req_Write;
    logic [ADDR_W-1:0] Req_Addr;
    logic [LEN_W-1:0]  Req_Len;
    logic [DATA_W-1:0] Wr_Data;
    logic              Wr_Valid;
    logic              Wr_Ready;
    logic [DATA_W-1:0] Rd_Data;
    logic              Rd_Valid;
    logic              Rd_Ready;
    logic              Busy;
    logic              Done;
    logic [ADDR_W-1:0] Mem_Address;
    logic [DATA_W-1:0] Mem_Wdata;
    logic              Mem_W_En;
    logic              Mem_R_En;
    logic [DATA_W-1:0] Mem_Rdata;

    modport master (
        input  Req_Valid, Req_Write, Req_Addr, Req_Len, Wr_Data, Wr_Valid, Rd_Ready, Mem_Rdata,
        output Req_Ready, Wr_Ready, Rd_Data, Rd_Valid, Busy, Done,
               Mem_Address, Mem_Wdata, Mem_W_En, Mem_R_En
    );

    modport slave (
        output Req_Valid, Req_Write, Req_Addr, Req_Len, Wr_Data, Wr_Valid, Rd_Ready, Mem_Rdata,
        input  Req_Ready, Wr_Ready, Rd_Data, Rd_Valid, Busy, Done,
               Mem_Address, Mem_Wdata, Mem_W_En, Mem_R_En
    );
endinterface

// File: rtl/mem_burst_master.sv
// mem_burst_master: sequences read/write bursts onto a 256x8 single-port data memory
module mem_burst_master
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int LEN_W  = MEM_LEN_W
) (
    input logic                CLK,
    input logic                RST,
    mem_burst_master_if.master bus
);
    state_t            state, nxt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  cnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              done;
    logic              accept, wr_fire, rd_issue, rd_take, last;

    // Strobes are gated by RST so a reset mid-burst stops memory traffic in the same cycle
    always_comb begin
        nxt      = state;
        accept   = state == ST_IDLE && bus.Req_Valid;
        wr_fire  = !RST && state == ST_WRITE && bus.Wr_Valid;
        rd_issue = !RST && state == ST_READ && (!rd_valid || bus.Rd_Ready);
        rd_take  = rd_valid && bus.Rd_Ready;
        last     = cnt == '0;
        case (state)
            ST_IDLE:  nxt = accept ? (bus.Req_Write ? ST_WRITE : ST_READ) : ST_IDLE;
            ST_WRITE: nxt = wr_fire && last ? ST_IDLE : ST_WRITE;
            ST_READ:  nxt = rd_issue && last ? ST_DRAIN : ST_READ;
            ST_DRAIN: nxt = rd_take ? ST_IDLE : ST_DRAIN;
            default:  nxt = ST_IDLE;
        endcase
        bus.Req_Ready   = state == ST_IDLE;
        bus.Wr_Ready    = state == ST_WRITE;
        bus.Busy        = state != ST_IDLE;
        bus.Done        = done;
        bus.Rd_Valid    = rd_valid;
        bus.Rd_Data     = rd_data;
        bus.Mem_W_En    = wr_fire;
        bus.Mem_R_En    = rd_issue;
        bus.Mem_Address = wr_fire || rd_issue ? addr : '0;
        bus.Mem_Wdata   = wr_fire ? bus.Wr_Data : '0;
    end

    // State, address/count, the one-entry read slot and the Done pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            addr     <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
        end else begin
            state <= nxt;
            done  <= (wr_fire && last) || (state == ST_DRAIN && rd_take);
            if (accept) begin
                addr <= bus.Req_Addr;
                cnt  <= bus.Req_Len;
            end else if (wr_fire || rd_issue) begin
                addr <= addr + 1'b1;
                cnt  <= last ? cnt : cnt - 1'b1;
            end
            if (rd_issue) begin
                rd_valid <= 1'b1;
                rd_data  <= bus.Mem_Rdata;
            end else if (rd_take) begin
                rd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: scoreboard bench for the burst master against a 256x8 memory model
module tb_mem_burst_master;
    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad = 0;
    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] wq [$];
    logic [7:0]  rq [$];
    logic [15:0] we;
    logic [7:0]  re;
    logic        hold;
    logic [7:0]  hold_d;

    mem_burst_master_if bus ();

    mem_burst_master dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Memory being driven: registered write, combinational read
    always @(posedge CLK) if (bus.Mem_W_En) mem[bus.Mem_Address] <= bus.Mem_Wdata;
    assign bus.Mem_Rdata = mem[bus.Mem_Address];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor: checks memory strobes and read-stream beats against the queues
    always @(negedge CLK) begin
        if (bus.Mem_W_En) begin
            if (wq.size() == 0) chk("wr_extra", bus.Mem_W_En, 0);
            else begin
                we = wq.pop_front();
                chk("wr_addr", bus.Mem_Address, we[15:8]);
                chk("wr_data", bus.Mem_Wdata, we[7:0]);
            end
        end
        chk("wen_ren_excl", bus.Mem_W_En & bus.Mem_R_En, 0);
        if (!bus.Mem_W_En && !bus.Mem_R_En) begin
            chk("idle_addr", bus.Mem_Address, 0);
            chk("idle_wdata", bus.Mem_Wdata, 0);
        end
        if (bus.Rd_Valid && !bus.Rd_Ready) chk("stall_ren", bus.Mem_R_En, 0);
        if (hold && !RST) begin
            chk("hold_valid", bus.Rd_Valid, 1);
            chk("hold_data", bus.Rd_Data, hold_d);
        end
        if (bus.Rd_Valid && bus.Rd_Ready) begin
            if (rq.size() == 0) chk("rd_extra", bus.Rd_Valid, 0);
            else begin
                re = rq.pop_front();
                chk("rd_data", bus.Rd_Data, re);
            end
        end
        hold   = bus.Rd_Valid && !bus.Rd_Ready && !RST;
        hold_d = bus.Rd_Data;
    end

    task automatic send_req(input logic w, input logic [7:0] a, input logic [3:0] len, input bit keep);
        int n = 0;
        while (!bus.Req_Ready && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("req_ready", bus.Req_Ready, 1);
        bus.Req_Valid = 1'b1;
        bus.Req_Write = w;
        bus.Req_Addr  = a;
        bus.Req_Len   = len;
        @(posedge CLK); #1;
        if (keep) begin
            bus.Req_Write = ~w;
            bus.Req_Addr  = ~a;
            bus.Req_Len   = ~len;
        end else bus.Req_Valid = 1'b0;
        chk("busy_after_accept", bus.Busy, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] len, input logic [7:0] d0,
                            input bit gaps, input bit keep);
        logic [7:0] ad, d;
        send_req(1'b1, a, len, keep);
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps && i % 2 == 1) begin
                bus.Wr_Valid = 1'b0;
                chk("wr_ready_gap", bus.Wr_Ready, 1);
                @(posedge CLK); #1;
            end
            ad = a + 8'(i);
            d  = d0 + 8'(i);
            bus.Wr_Valid = 1'b1;
            bus.Wr_Data  = d;
            chk("wr_ready", bus.Wr_Ready, 1);
            if (keep) chk("req_ready_busy", bus.Req_Ready, 0);
            wq.push_back({ad, d});
            ref_mem[ad] = d;
            @(posedge CLK); #1;
        end
        bus.Wr_Valid  = 1'b0;
        bus.Req_Valid = 1'b0;
        chk("wr_done", bus.Done, 1);
        chk("wr_idle", bus.Busy, 0);
        @(posedge CLK); #1;
        chk("wr_done_pulse", bus.Done, 0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] len, input bit toggle);
        int acc = 0;
        int k = 0;
        send_req(1'b0, a, len, 1'b0);
        for (int i = 0; i <= int'(len); i++) rq.push_back(ref_mem[a + 8'(i)]);
        while (acc <= int'(len) && k < 200) begin
            bus.Rd_Ready = toggle ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            @(negedge CLK);
            if (bus.Rd_Valid && bus.Rd_Ready) acc++;
            @(posedge CLK); #1;
            k++;
        end
        bus.Rd_Ready = 1'b0;
        chk("rd_beats", acc, int'(len) + 1);
        chk("rd_done", bus.Done, 1);
        chk("rd_valid_cleared", bus.Rd_Valid, 0);
        @(posedge CLK); #1;
        chk("rd_done_pulse", bus.Done, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        hold          = 1'b0;
        hold_d        = 8'h00;
        RST           = 1'b1;
        bus.Req_Valid = 1'b0;
        bus.Req_Write = 1'b0;
        bus.Req_Addr  = 8'h00;
        bus.Req_Len   = 4'h0;
        bus.Wr_Data   = 8'h00;
        bus.Wr_Valid  = 1'b0;
        bus.Rd_Ready  = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        chk("rst_req_ready", bus.Req_Ready, 1);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_rd_valid", bus.Rd_Valid, 0);
        chk("rst_rd_data", bus.Rd_Data, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_wen", bus.Mem_W_En, 0);
        chk("rst_ren", bus.Mem_R_En, 0);

        do_write(8'h10, 4'd0, 8'hA5, 1'b0, 1'b0);
        chk("mem16", mem[8'h10], 8'hA5);
        do_write(8'hFE, 4'd3, 8'h01, 1'b0, 1'b0);
        chk("mem_wrap", mem[8'h01], 8'h04);
        do_read(8'hFE, 4'd3, 1'b0);
        do_read(8'hFE, 4'd3, 1'b1);
        do_read(8'h10, 4'd0, 1'b0);
        do_write(8'h20, 4'd5, 8'h30, 1'b1, 1'b0);
        do_read(8'h20, 4'd5, 1'b1);
        do_write(8'h40, 4'd2, 8'hC0, 1'b0, 1'b1);
        do_read(8'h40, 4'd2, 1'b0);

        send_req(1'b1, 8'h80, 4'd7, 1'b0);
        for (int i = 0; i < 2; i++) begin
            bus.Wr_Valid = 1'b1;
            bus.Wr_Data  = 8'h90 + 8'(i);
            wq.push_back({8'h80 + 8'(i), 8'h90 + 8'(i)});
            ref_mem[8'h80 + 8'(i)] = 8'h90 + 8'(i);
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("abort_busy", bus.Busy, 0);
        chk("abort_rd_valid", bus.Rd_Valid, 0);
        chk("abort_req_ready", bus.Req_Ready, 1);
        @(posedge CLK); #1;
        bus.Wr_Valid = 1'b0;
        chk("abort_mem82", mem[8'h82], 8'h00);
        do_write(8'h82, 4'd0, 8'h77, 1'b0, 1'b0);
        do_read(8'h80, 4'd3, 1'b0);

        send_req(1'b0, 8'hFE, 4'd3, 1'b0);
        bus.Rd_Ready = 1'b0;
        @(posedge CLK); #1;
        chk("pend_rd_valid", bus.Rd_Valid, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("pend_dropped", bus.Rd_Valid, 0);
        chk("pend_busy", bus.Busy, 0);
        do_read(8'h00, 4'd1, 1'b1);

        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
